// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, 2^ADDR_W-deep instruction store with a programming port,
// fetch-time resolution of JMP/HALT, and a downstream stall that freezes the whole stage.
module instruction_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_prog_en,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [INS_W-1:0]  i_prog_data,
  input  logic              i_run,
  input  logic              i_stall,
  output logic [INS_W-1:0]  o_ins,
  output logic              o_ins_valid,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic              o_halted,
  output logic [15:0]       o_fetch_count
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_JMP  = 5'b11100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INS_W-1:0]   r_ins;
  logic               r_ins_valid;
  logic               r_halted;
  logic [15:0]        r_fetch_count;

  logic [INS_W-1:0]   r_mem [DEPTH];

  logic [INS_W-1:0]   w_fetch_word;
  logic [4:0]         w_opcode;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [15:0]        w_count_inc;
  logic               w_prog_we;

  // Asynchronous read so a JMP target is fetched on the very next edge (no bubble).
  assign w_fetch_word = r_mem[r_pc];
  assign w_opcode     = w_fetch_word[INS_W-1 -: 5];
  assign w_pc_inc     = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_count_inc  = (r_fetch_count == 16'hFFFF) ? r_fetch_count : r_fetch_count + 16'd1;
  assign w_prog_we    = (r_state == S_IDLE) && i_prog_en;

  // Store is deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge i_clk) begin
    if (w_prog_we) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_ins         <= '0;
      r_ins_valid   <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state       <= S_RUN;
            r_pc          <= '0;
            r_fetch_count <= '0;
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            if (w_opcode == OP_HALT) begin
              r_state     <= S_HALT;
              r_ins       <= '0;
              r_ins_valid <= 1'b0;
              r_halted    <= 1'b1;
            end else begin
              r_ins         <= w_fetch_word;
              r_ins_valid   <= 1'b1;
              r_fetch_count <= w_count_inc;
              r_pc          <= (w_opcode == OP_JMP) ? w_fetch_word[ADDR_W-1:0] : w_pc_inc;
            end
          end
        end
        S_HALT: begin
          r_ins       <= '0;
          r_ins_valid <= 1'b0;
          if (i_run) begin
            r_state       <= S_RUN;
            r_pc          <= '0;
            r_fetch_count <= '0;
            r_halted      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ins         = r_ins;
  assign o_ins_valid   = r_ins_valid;
  assign o_pc_out      = r_pc;
  assign o_halted      = r_halted;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized programs,
// checked against a program-trace model (list of issued words advanced once per unstalled cycle).
module tb_instruction_fetch_unit;

  localparam logic [4:0]  OP_HALT = 5'b11111;
  localparam logic [4:0]  OP_JMP  = 5'b11100;
  localparam logic [19:0] W_HALT  = 20'hF8000;

  logic        clk = 1'b0;
  logic        i_reset, i_prog_en, i_run, i_stall;
  logic [7:0]  i_prog_addr;
  logic [19:0] i_prog_data;
  logic [19:0] o_ins;
  logic        o_ins_valid;
  logic [7:0]  o_pc_out;
  logic        o_halted;
  logic [15:0] o_fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: store contents, traced issue list for the current run, and progress through it.
  logic [19:0] m_mem [256];
  logic [19:0] q_words [$];
  logic [7:0]  q_pcs [$];
  bit          t_halts;
  int          e_n;
  bit          e_halt;
  bit          e_started;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.ADDR_W(8), .INS_W(20)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_prog_en     (i_prog_en),
    .i_prog_addr   (i_prog_addr),
    .i_prog_data   (i_prog_data),
    .i_run         (i_run),
    .i_stall       (i_stall),
    .o_ins         (o_ins),
    .o_ins_valid   (o_ins_valid),
    .o_pc_out      (o_pc_out),
    .o_halted      (o_halted),
    .o_fetch_count (o_fetch_count)
  );

  // Walk the program from address 0 and record every issued word and the PC after it.
  function automatic void trace();
    logic [7:0]  pc;
    logic [19:0] w;
    q_words.delete();
    q_pcs.delete();
    t_halts = 1'b0;
    pc = 8'h00;
    for (int i = 0; i < 300; i++) begin
      w = m_mem[pc];
      if (w[19:15] == OP_HALT) begin
        t_halts = 1'b1;
        break;
      end
      q_words.push_back(w);
      if (w[19:15] == OP_JMP) pc = w[7:0];
      else pc = pc + 8'd1;
      q_pcs.push_back(pc);
    end
  endfunction

  function automatic logic [45:0] exp_vec();
    logic [19:0] ins;
    logic        v;
    logic [7:0]  pc;
    logic        h;
    logic [15:0] fc;
    ins = '0; v = 1'b0; pc = '0; h = 1'b0; fc = '0;
    if (e_started) begin
      fc = 16'(e_n);
      if (e_n > 0) pc = q_pcs[e_n-1];
      if (e_halt) h = 1'b1;
      else if (e_n > 0) begin
        ins = q_words[e_n-1];
        v = 1'b1;
      end
    end
    return {ins, v, pc, h, fc};
  endfunction

  function automatic logic [45:0] got_vec();
    return {o_ins, o_ins_valid, o_pc_out, o_halted, o_fetch_count};
  endfunction

  function automatic logic [19:0] rand_plain_word();
    logic [4:0] op;
    op = 5'($urandom_range(0, 27));
    return {op, 15'($urandom)};
  endfunction

  task automatic cycle(input bit s);
    i_stall = s;
    @(negedge clk);
    if (e_started && !e_halt && !s) begin
      if (e_n < q_words.size()) e_n++;
      else if (t_halts) e_halt = 1'b1;
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [19:0] d, input bit effective);
    i_prog_en = 1'b1;
    i_prog_addr = a;
    i_prog_data = d;
    @(negedge clk);
    i_prog_en = 1'b0;
    if (effective) m_mem[a] = d;
  endtask

  task automatic start_run();
    i_run = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
    trace();
    e_started = 1'b1;
    e_n = 0;
    e_halt = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 i_reset = 1'b1;
    #2 i_reset = 1'b0;
    e_started = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (got_vec() !== 46'h0) begin
      n_errors++;
      $display("FAIL reset_async: got {ins,v,pc,h,cnt}=%h want 0", got_vec());
    end
    @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_idle: got %h want %h", got_vec(), exp_vec());
    end
    for (int a = 0; a < 256; a++) write_word(8'(a), rand_plain_word(), 1'b1);
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL idle_after_prog: got %h want %h", got_vec(), exp_vec());
    end
    $display("test_reset done");
  endtask

  task automatic test_program_sequence();
    logic [19:0] want_ins [4];
    want_ins[0] = 20'h08421; want_ins[1] = 20'h10C62; want_ins[2] = 20'h18000; want_ins[3] = 20'h00000;
    write_word(8'd0, 20'h08421, 1'b1);
    write_word(8'd1, 20'h10C62, 1'b1);
    write_word(8'd2, 20'h18000, 1'b1);
    write_word(8'd3, W_HALT, 1'b1);
    start_run();
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL seq_start: got %h want %h", got_vec(), exp_vec());
    end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL seq_model cyc%0d: got %h want %h", c, got_vec(), exp_vec());
      end
      n_checks++;
      if (o_ins !== want_ins[c] || o_ins_valid !== (c < 3)) begin
        n_errors++;
        $display("FAIL seq_ins cyc%0d: got ins=%h v=%b want ins=%h v=%b", c, o_ins, o_ins_valid, want_ins[c], c < 3);
      end
    end
    n_checks++;
    if (o_halted !== 1'b1 || o_fetch_count !== 16'd3) begin
      n_errors++;
      $display("FAIL seq_halt: got halted=%b cnt=%0d want 1 3", o_halted, o_fetch_count);
    end
    $display("test_program_sequence done");
    reset_pulse();
  endtask

  task automatic test_jump();
    logic [7:0] want_pc [3];
    want_pc[0] = 8'd5; want_pc[1] = 8'd6; want_pc[2] = 8'd6;
    write_word(8'd0, 20'hE0005, 1'b1);
    write_word(8'd5, 20'h08001, 1'b1);
    write_word(8'd6, W_HALT, 1'b1);
    start_run();
    n_checks++;
    if (o_pc_out !== 8'd0) begin
      n_errors++;
      $display("FAIL jmp_pc0: got pc=%h want 00", o_pc_out);
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL jmp_model cyc%0d: got %h want %h", c, got_vec(), exp_vec());
      end
      n_checks++;
      if (o_pc_out !== want_pc[c]) begin
        n_errors++;
        $display("FAIL jmp_pc cyc%0d: got pc=%h want %h", c, o_pc_out, want_pc[c]);
      end
    end
    $display("test_jump done");
    reset_pulse();
  endtask

  task automatic test_stall();
    logic [19:0] w1;
    for (int a = 0; a < 4; a++) write_word(8'(a), rand_plain_word(), 1'b1);
    write_word(8'd4, W_HALT, 1'b1);
    w1 = m_mem[1];
    start_run();
    cycle(1'b0);
    cycle(1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1);
      n_checks++;
      if (o_ins !== w1 || o_pc_out !== 8'd2 || o_fetch_count !== 16'd2) begin
        n_errors++;
        $display("FAIL stall_hold cyc%0d: got ins=%h pc=%h cnt=%0d want %h 02 2", c, o_ins, o_pc_out, o_fetch_count, w1);
      end
    end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL stall_release cyc%0d: got %h want %h", c, got_vec(), exp_vec());
      end
    end
    $display("test_stall done");
    reset_pulse();
  endtask

  task automatic test_wrap();
    write_word(8'h00, 20'hE00FF, 1'b1);
    write_word(8'hFF, 20'h08001, 1'b1);
    write_word(8'h01, W_HALT, 1'b1);
    start_run();
    for (int c = 0; c < 8; c++) begin
      cycle(c == 4);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL wrap_model cyc%0d: got %h want %h", c, got_vec(), exp_vec());
      end
      if (c == 1) begin
        n_checks++;
        if (o_ins !== 20'h08001 || o_pc_out !== 8'h00) begin
          n_errors++;
          $display("FAIL wrap_pc: got ins=%h pc=%h want 08001 00", o_ins, o_pc_out);
        end
      end
    end
    reset_pulse();
    write_word(8'h00, W_HALT, 1'b1);
    start_run();
    cycle(1'b0);
    n_checks++;
    if (o_halted !== 1'b1 || o_fetch_count !== 16'd0 || o_pc_out !== 8'h00 || o_ins_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_at_0: got h=%b cnt=%0d pc=%h v=%b want 1 0 00 0", o_halted, o_fetch_count, o_pc_out, o_ins_valid);
    end
    $display("test_wrap done");
    reset_pulse();
  endtask

  task automatic test_protection();
    for (int a = 0; a < 3; a++) write_word(8'(a), rand_plain_word(), 1'b1);
    write_word(8'd3, W_HALT, 1'b1);
    start_run();
    cycle(1'b0);
    i_prog_en = 1'b1;
    i_prog_addr = 8'd2;
    i_prog_data = W_HALT;
    cycle(1'b0);
    i_prog_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL prot_run cyc%0d: got %h want %h", c, got_vec(), exp_vec());
      end
    end
    write_word(8'd1, W_HALT, 1'b0);
    start_run();
    n_checks++;
    if (o_pc_out !== 8'd0 || o_fetch_count !== 16'd0 || o_halted !== 1'b0) begin
      n_errors++;
      $display("FAIL restart: got pc=%h cnt=%0d h=%b want 00 0 0", o_pc_out, o_fetch_count, o_halted);
    end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL prot_rerun cyc%0d: got %h want %h", c, got_vec(), exp_vec());
      end
    end
    $display("test_protection done");
    reset_pulse();
  endtask

  task automatic test_async_reset();
    for (int a = 0; a < 6; a++) write_word(8'(a), rand_plain_word(), 1'b1);
    write_word(8'd6, W_HALT, 1'b1);
    start_run();
    repeat (3) cycle(1'b0);
    #2 i_reset = 1'b1;
    #1;
    e_started = 1'b0;
    n_checks++;
    if (o_ins !== 20'h0 || o_ins_valid !== 1'b0 || o_pc_out !== 8'h00) begin
      n_errors++;
      $display("FAIL async_reset: got ins=%h v=%b pc=%h want 00000 0 00", o_ins, o_ins_valid, o_pc_out);
    end
    #1 i_reset = 1'b0;
    @(negedge clk);
    start_run();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL async_replay cyc%0d: got %h want %h", c, got_vec(), exp_vec());
      end
    end
    $display("test_async_reset done");
    reset_pulse();
  endtask

  task automatic test_random();
    logic [19:0] w;
    int          r;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 16; a++) begin
        r = $urandom_range(0, 9);
        if (r == 0) w = W_HALT;
        else if (r <= 2) w = {OP_JMP, 11'($urandom), 4'h0, 4'($urandom_range(0, 15))};
        else w = rand_plain_word();
        write_word(8'(a), w, 1'b1);
      end
      start_run();
      for (int c = 0; c < 40; c++) begin
        i_run = (!e_halt && $urandom_range(0, 9) == 0);
        cycle($urandom_range(0, 9) < 3);
        i_run = 1'b0;
        n_checks++;
        if (got_vec() !== exp_vec()) begin
          n_errors++;
          $display("FAIL random it%0d cyc%0d: got %h want %h", it, c, got_vec(), exp_vec());
        end
      end
      $display("test_random iteration %0d done", it);
      reset_pulse();
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_prog_en = 1'b0;
    i_prog_addr = '0;
    i_prog_data = '0;
    i_run = 1'b0;
    i_stall = 1'b0;
    e_started = 1'b0;
    e_n = 0;
    e_halt = 1'b0;
    t_halts = 1'b0;
    test_reset();
    test_program_sequence();
    test_jump();
    test_stall();
    test_wrap();
    test_protection();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
